button_conditioner: RTL and testbench

Conditions a raw, asynchronous push-button or switch level into a clean, clock-synchronous level with single-cycle edge strobes. It sits directly upstream of the SDAD control fabric, including the period generator and mode logic, and feeds them user-input events. The block has a 2-FF synchronizer, a stability counter and a 4-state FSM. Optionally it also flags long presses.

---
 rtl/button_conditioner.sv | 170 +++++++++++++++++
 tb/tb_button_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Debounces a raw button level: 2-FF synchronizer, stability counter and 4-state FSM
// with registered rise/fall strobes. Define BUTTON_COND_LONGPRESS_EN to add the long-press strobe.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_LOW     | out=0, input stable low
// ST_TO_HIGH | out=0, input high, qualifying for C_CYCLES
// ST_HIGH    | out=1, input stable high
// ST_TO_LOW  | out=1, input low, qualifying for C_CYCLES
module button_conditioner #(
    parameter int C_CLK_FRQ       = 100_000_000,
    parameter int C_INTERVAL      = 10,
    parameter int C_LONG_INTERVAL = 1000
) (
    input  logic clk,
    input  logic rstb,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic long
);

    // Divide first so large clock rates times milliseconds stay within 32 bits.
    localparam int C_CYCLES = (C_CLK_FRQ / 1000) * C_INTERVAL;
    localparam int CNT_W    = $clog2(C_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (C_CYCLES < 2 || C_LONG_INTERVAL <= C_INTERVAL) begin : g_bad_cfg
        $error("button_conditioner: illegal interval configuration");
    end

    typedef enum logic [1:0] {
        ST_LOW,
        ST_TO_HIGH,
        ST_HIGH,
        ST_TO_LOW
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        s1_d    = in;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (s2_q) begin
                    state_d = ST_TO_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_TO_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_TO_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_TO_LOW: begin
                if (s2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef BUTTON_COND_LONGPRESS_EN
    localparam int C_LONG_CYCLES = (C_CLK_FRQ / 1000) * C_LONG_INTERVAL;
    localparam int LCNT_W        = $clog2(C_LONG_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(C_LONG_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_FIRE = LCNT_W'(C_LONG_CYCLES - 2);
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              long_q, long_d;
    logic              long_run;

    // The rise cycle itself is not counted, so long lands C_LONG_CYCLES after rise.
    always_comb begin
        long_run = (state_q == ST_HIGH || state_q == ST_TO_LOW) && !rise_q;
        lcnt_d   = lcnt_q;
        if (state_d == ST_LOW) begin
            lcnt_d = '0;
        end else if (long_run && lcnt_q != LCNT_MAX) begin
            lcnt_d = lcnt_q + LCNT_ONE;
        end
        long_d = long_run && (lcnt_q == LCNT_FIRE) && !fall_d;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
        end
    end

    assign long = long_q;
`else
    assign long = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: C_CYCLES=10, C_LONG_CYCLES=50.
// Long-press expectations follow BUTTON_COND_LONGPRESS_EN.
module tb_button_conditioner;

    localparam int P_FRQ  = 10_000;
    localparam int P_INT  = 1;
    localparam int P_LONG = 5;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    logic in_r = 1'b0;
    logic out_w, rise_w, fall_w, long_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic in_v;
        logic e_out;
        logic e_rise;
        logic e_fall;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .C_CLK_FRQ      (P_FRQ),
        .C_INTERVAL     (P_INT),
        .C_LONG_INTERVAL(P_LONG)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .in  (in_r),
        .out (out_w),
        .rise(rise_w),
        .fall(fall_w),
        .long(long_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // A run of n cycles at level v; out flips at index 'at' (-1: never) with the matching strobe.
    task automatic add_run(input logic v, input int n, input logic o0, input int at);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e.in_v   = v;
            e.e_out  = (at >= 0 && i >= at) ? ~o0 : o0;
            e.e_rise = (i == at) && !o0;
            e.e_fall = (i == at) && o0;
            vecs.push_back(e);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_out"},  out_w,  1'b0);
        chk({name, "_rise"}, rise_w, 1'b0);
        chk({name, "_fall"}, fall_w, 1'b0);
        chk({name, "_long"}, long_w, 1'b0);
    endtask

    initial begin
        int n_rise, n_long, rise_at, long_at;

        // Reset held with a toggling input: everything stays low.
        rstb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_r = ~in_r;
            tick();
            chk_idle("rst_hold");
        end

        // Release with input held high: full latency from the first edge after release.
        in_r = 1'b1;
        rstb = 1'b1;
        for (int e = 0; e < 13; e++) begin
            tick();
            chk("rel_out",  out_w,  (e >= 11));
            chk("rel_rise", rise_w, (e == 11));
        end
        in_r = 1'b0;
        repeat (14) tick();
        chk("rel_back_low", out_w, 1'b0);

        // Table: clean press/release, bounces, last-cycle aborts, chatter.
        add_run(1'b1, 15, 1'b0, 11);
        add_run(1'b0, 15, 1'b1, 11);
        add_run(1'b1, 9,  1'b0, -1);
        add_run(1'b0, 1,  1'b0, -1);
        add_run(1'b1, 9,  1'b0, -1);
        add_run(1'b0, 6,  1'b0, -1);
        add_run(1'b1, 9,  1'b0, -1);
        add_run(1'b0, 3,  1'b0, -1);
        add_run(1'b1, 14, 1'b0, 11);
        add_run(1'b0, 9,  1'b1, -1);
        add_run(1'b1, 3,  1'b1, -1);
        add_run(1'b0, 14, 1'b1, 11);
        for (int k = 0; k < 6; k++) begin
            add_run(1'b1, 4, 1'b0, -1);
            add_run(1'b0, 4, 1'b0, -1);
        end
        add_run(1'b0, 4, 1'b0, -1);

        for (int i = 0; i < vecs.size(); i++) begin
            in_r = vecs[i].in_v;
            tick();
            chk("tbl_out",  out_w,  vecs[i].e_out);
            chk("tbl_rise", rise_w, vecs[i].e_rise);
            chk("tbl_fall", fall_w, vecs[i].e_fall);
            chk("tbl_long", long_w, 1'b0);
        end

        // Long hold of 100 cycles.
        n_rise = 0; n_long = 0; rise_at = -1; long_at = -1;
        in_r = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (rise_w) begin n_rise++; rise_at = c; end
            if (long_w) begin n_long++; long_at = c; end
        end
        chk_int("long_rise_cnt", n_rise, 1);
        chk_int("long_rise_at",  rise_at, 11);
`ifdef BUTTON_COND_LONGPRESS_EN
        chk_int("long_cnt", n_long, 1);
        chk_int("long_at",  long_at, 61);
`else
        chk_int("long_cnt", n_long, 0);
`endif
        in_r = 1'b0;
        repeat (14) tick();
        chk("long_back_low", out_w, 1'b0);

        // Async reset in the middle of a TO_LOW count.
        in_r = 1'b1;
        repeat (12) tick();
        chk("ar_high", out_w, 1'b1);
        in_r = 1'b0;
        repeat (7) tick();
        chk("ar_mid_cnt", out_w, 1'b1);
        #2;
        rstb = 1'b0;
        #1;
        chk_idle("ar_async");
        in_r = 1'b1;
        repeat (3) begin
            tick();
            chk_idle("ar_held");
        end
        rstb = 1'b1;
        for (int e = 0; e < 13; e++) begin
            tick();
            chk("ar_req_out",  out_w,  (e >= 11));
            chk("ar_req_rise", rise_w, (e == 11));
            chk("ar_req_fall", fall_w, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
